chan_poll_ctl: RTL and testbench

Channel-side poll sequencer for the parallel channel "B" bus/tag interface. When a control unit raises request_in and polling is enabled, it drives hold_out/select_out down the select chain. It then completes the CU-initiated selection: address-in/command-out, then status-in/service-out. It reports the polled device address and status byte to an AXI-lite register block, sitting between that register block and the channel I/O pins.

---
 rtl/chan_poll_ctl_pkg.sv | 41 ++++
 rtl/chan_tag_sync.sv | 29 ++
 rtl/chan_poll_ctl.sv | 226 ++++++++++++++++++++++
 tb/tb_chan_poll_ctl.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/chan_poll_ctl_pkg.sv
// Shared types and constants for the channel-B poll sequencer.
package chan_poll_ctl_pkg;

  // Poll sequencer states.
  typedef enum logic [2:0] {
    ST_IDLE        = 3'd0,
    ST_SELECT      = 3'd1,
    ST_ADDR_ACK    = 3'd2,
    ST_WAIT_STATUS = 3'd3,
    ST_STATUS_ACK  = 3'd4,
    ST_RELEASE     = 3'd5,
    ST_END         = 3'd6
  } poll_state_e;

  typedef logic [1:0] poll_result_t;

  localparam poll_result_t RESULT_OK          = 2'd0;
  localparam poll_result_t RESULT_NO_RESPONSE = 2'd1;
  localparam poll_result_t RESULT_TIMEOUT     = 2'd2;

  // Width of the per-state wait timer.
  localparam int unsigned TMO_CNT_W = 16;

  // Bit positions of the inbound tags inside the synchronised tag vector.
  localparam int unsigned TAG_W    = 5;
  localparam int unsigned TAG_REQ  = 0;
  localparam int unsigned TAG_OPER = 1;
  localparam int unsigned TAG_ADDR = 2;
  localparam int unsigned TAG_STAT = 3;
  localparam int unsigned TAG_SEL  = 4;

  localparam int unsigned BUS_W = 8;

  // States in which the CU is being waited on and the timer runs.
  function automatic logic is_wait_state(input poll_state_e s);
    return (s == ST_SELECT)      || (s == ST_ADDR_ACK)   ||
           (s == ST_WAIT_STATUS) || (s == ST_STATUS_ACK) ||
           (s == ST_RELEASE);
  endfunction

endpackage

// File: rtl/chan_tag_sync.sv
// Two-flop synchronizer for inbound channel tags and bus bits.
// Each bit is synchronised independently; multi-bit values are only
// consumed while their qualifying tag guarantees they are stable.
module chan_tag_sync #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  // Two-stage capture of the asynchronous inputs.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/chan_poll_ctl.sv
// Channel-side poll sequencer for the parallel channel B bus/tag
// interface. Raises hold/select for a requesting CU, completes the
// address-in/command-out and status-in/service-out handshakes, and
// reports the polled address and status byte with a result code.
module chan_poll_ctl
  import chan_poll_ctl_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 4096
) (
  input  logic             aclk,
  input  logic             aresetn,
  input  logic             poll_enable,
  input  logic [BUS_W-1:0] b_bus_in,
  input  logic             b_request_in,
  input  logic             b_operational_in,
  input  logic             b_address_in,
  input  logic             b_status_in,
  input  logic             b_select_in,
  output logic             b_hold_out,
  output logic             b_select_out,
  output logic             b_command_out,
  output logic             b_service_out,
  output logic             poll_busy,
  output logic             poll_done,
  output logic [1:0]       poll_result,
  output logic [BUS_W-1:0] poll_address,
  output logic [BUS_W-1:0] poll_status
);

  localparam logic [TMO_CNT_W-1:0] TMO_LAST = TMO_CNT_W'(TIMEOUT_CYCLES - 1);

  logic [TAG_W-1:0] tag_pins;
  logic [TAG_W-1:0] tag_s;
  logic [BUS_W-1:0] bus_s;

  logic req_s;
  logic oper_s;
  logic addr_s;
  logic stat_s;
  logic selin_s;

  poll_state_e          state_q;
  logic [TMO_CNT_W-1:0] cnt_q;
  logic                 hold_q;
  logic                 sel_q;
  logic                 cmd_q;
  logic                 svc_q;
  logic                 busy_q;
  logic                 done_q;
  poll_result_t         result_q;
  logic [BUS_W-1:0]     addr_q;
  logic [BUS_W-1:0]     status_q;

  logic exit_c;
  logic tmo_hit;
  logic abort_c;

  assign tag_pins = {b_select_in, b_status_in, b_address_in,
                     b_operational_in, b_request_in};

  chan_tag_sync #(
    .WIDTH(TAG_W)
  ) u_tag_sync (
    .clk_i (aclk),
    .rst_ni(aresetn),
    .d_i   (tag_pins),
    .q_o   (tag_s)
  );

  chan_tag_sync #(
    .WIDTH(BUS_W)
  ) u_bus_sync (
    .clk_i (aclk),
    .rst_ni(aresetn),
    .d_i   (b_bus_in),
    .q_o   (bus_s)
  );

  assign req_s   = tag_s[TAG_REQ];
  assign oper_s  = tag_s[TAG_OPER];
  assign addr_s  = tag_s[TAG_ADDR];
  assign stat_s  = tag_s[TAG_STAT];
  assign selin_s = tag_s[TAG_SEL];

  // Exit condition of the current wait state; gates timer expiry.
  always_comb begin
    exit_c = 1'b0;
    case (state_q)
      ST_SELECT:      exit_c = (oper_s && addr_s) || selin_s;
      ST_ADDR_ACK:    exit_c = !addr_s;
      ST_WAIT_STATUS: exit_c = stat_s;
      ST_STATUS_ACK:  exit_c = !stat_s;
      ST_RELEASE:     exit_c = !oper_s;
      default:        exit_c = 1'b0;
    endcase
  end

  assign tmo_hit = (cnt_q == TMO_LAST);
  // Expiry is factored out of the per-state branches: it only fires when
  // that state's exit condition is false, so the exit always wins.
  assign abort_c = is_wait_state(state_q) && !exit_c && tmo_hit;

  // Poll sequencer with registered tag and status outputs.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      hold_q   <= 1'b0;
      sel_q    <= 1'b0;
      cmd_q    <= 1'b0;
      svc_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= RESULT_OK;
      addr_q   <= '0;
      status_q <= '0;
    end else begin
      done_q <= 1'b0;
      cnt_q  <= is_wait_state(state_q) ? cnt_q + 1'b1 : '0;
      if (abort_c) begin
        hold_q   <= 1'b0;
        sel_q    <= 1'b0;
        cmd_q    <= 1'b0;
        svc_q    <= 1'b0;
        result_q <= RESULT_TIMEOUT;
        done_q   <= 1'b1;
        cnt_q    <= '0;
        state_q  <= ST_END;
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (poll_enable && req_s) begin
              hold_q  <= 1'b1;
              sel_q   <= 1'b1;
              busy_q  <= 1'b1;
              cnt_q   <= '0;
              state_q <= ST_SELECT;
            end
          end
          ST_SELECT: begin
            if (oper_s && addr_s) begin
              addr_q  <= bus_s;
              cmd_q   <= 1'b1;
              cnt_q   <= '0;
              state_q <= ST_ADDR_ACK;
            end else if (selin_s) begin
              sel_q    <= 1'b0;
              hold_q   <= 1'b0;
              result_q <= RESULT_NO_RESPONSE;
              done_q   <= 1'b1;
              cnt_q    <= '0;
              state_q  <= ST_END;
            end
          end
          ST_ADDR_ACK: begin
            if (!addr_s) begin
              cmd_q   <= 1'b0;
              cnt_q   <= '0;
              state_q <= ST_WAIT_STATUS;
            end
          end
          ST_WAIT_STATUS: begin
            if (stat_s) begin
              status_q <= bus_s;
              svc_q    <= 1'b1;
              cnt_q    <= '0;
              state_q  <= ST_STATUS_ACK;
            end
          end
          ST_STATUS_ACK: begin
            if (!stat_s) begin
              svc_q   <= 1'b0;
              sel_q   <= 1'b0;
              hold_q  <= 1'b0;
              cnt_q   <= '0;
              state_q <= ST_RELEASE;
            end
          end
          ST_RELEASE: begin
            if (!oper_s) begin
              result_q <= RESULT_OK;
              done_q   <= 1'b1;
              cnt_q    <= '0;
              state_q  <= ST_END;
            end
          end
          ST_END: begin
            busy_q  <= 1'b0;
            cnt_q   <= '0;
            state_q <= ST_IDLE;
          end
          default: begin
            hold_q  <= 1'b0;
            sel_q   <= 1'b0;
            cmd_q   <= 1'b0;
            svc_q   <= 1'b0;
            busy_q  <= 1'b0;
            cnt_q   <= '0;
            state_q <= ST_IDLE;
          end
        endcase
      end
    end
  end

  assign b_hold_out    = hold_q;
  assign b_select_out  = sel_q;
  assign b_command_out = cmd_q;
  assign b_service_out = svc_q;
  assign poll_busy     = busy_q;
  assign poll_done     = done_q;
  assign poll_result   = result_q;
  assign poll_address  = addr_q;
  assign poll_status   = status_q;

  // Structural invariants of the sequencer.
  a_done_single : assert property (@(posedge aclk) disable iff (!aresetn)
    poll_done |=> !poll_done);
  a_done_busy : assert property (@(posedge aclk) disable iff (!aresetn)
    poll_done |-> poll_busy);
  a_cmd_held : assert property (@(posedge aclk) disable iff (!aresetn)
    b_command_out |-> (b_hold_out && b_select_out));
  a_result_legal : assert property (@(posedge aclk) disable iff (!aresetn)
    poll_result != 2'd3);

endmodule

// File: tb/tb_chan_poll_ctl.sv
// Scoreboard bench for chan_poll_ctl: directed CU behaviours push their
// expected poll outcome; a monitor pops and compares on every poll_done.
module tb_chan_poll_ctl;
  import chan_poll_ctl_pkg::*;

  localparam int W_HOLD = 0;
  localparam int W_SEL  = 1;
  localparam int W_CMD  = 2;
  localparam int W_SVC  = 3;
  localparam int W_BUSY = 4;
  localparam int W_DONE = 5;
  localparam int BUDGET = 60;

  logic       aclk = 1'b0;
  logic       aresetn;
  logic       poll_enable;
  logic [7:0] b_bus_in;
  logic       b_request_in;
  logic       b_operational_in;
  logic       b_address_in;
  logic       b_status_in;
  logic       b_select_in;
  logic       b_hold_out;
  logic       b_select_out;
  logic       b_command_out;
  logic       b_service_out;
  logic       poll_busy;
  logic       poll_done;
  logic [1:0] poll_result;
  logic [7:0] poll_address;
  logic [7:0] poll_status;

  typedef struct {
    logic [1:0] result;
    logic [7:0] addr;
    logic [7:0] status;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  chan_poll_ctl #(
    .TIMEOUT_CYCLES(16)
  ) dut (
    .aclk            (aclk),
    .aresetn         (aresetn),
    .poll_enable     (poll_enable),
    .b_bus_in        (b_bus_in),
    .b_request_in    (b_request_in),
    .b_operational_in(b_operational_in),
    .b_address_in    (b_address_in),
    .b_status_in     (b_status_in),
    .b_select_in     (b_select_in),
    .b_hold_out      (b_hold_out),
    .b_select_out    (b_select_out),
    .b_command_out   (b_command_out),
    .b_service_out   (b_service_out),
    .poll_busy       (poll_busy),
    .poll_done       (poll_done),
    .poll_result     (poll_result),
    .poll_address    (poll_address),
    .poll_status     (poll_status)
  );

  always #5 aclk = ~aclk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic get_out(input int which);
    case (which)
      W_HOLD:  return b_hold_out;
      W_SEL:   return b_select_out;
      W_CMD:   return b_command_out;
      W_SVC:   return b_service_out;
      W_BUSY:  return poll_busy;
      W_DONE:  return poll_done;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] all_outs();
    return 32'({b_hold_out, b_select_out, b_command_out, b_service_out, poll_busy,
                poll_done, poll_result, poll_address, poll_status});
  endfunction

  function automatic logic [31:0] tags_out();
    return 32'({b_hold_out, b_select_out, b_command_out, b_service_out});
  endfunction

  // Waits (bounded) on negedges for an output to reach a level, then checks it.
  task automatic wait_out(input int which, input logic val, input string name);
    int n = 0;
    while (get_out(which) !== val && n < BUDGET) begin
      @(negedge aclk);
      n++;
    end
    check(name, 32'(get_out(which)), 32'(val));
  endtask

  task automatic push_exp(input logic [1:0] r, input logic [7:0] a, input logic [7:0] s);
    exp_t e;
    e.result = r;
    e.addr   = a;
    e.status = s;
    sb.push_back(e);
  endtask

  // A CU that completes the full selection sequence.
  task automatic ok_poll(input logic [7:0] a, input logic [7:0] s, input string tag);
    push_exp(RESULT_OK, a, s);
    poll_enable  = 1'b1;
    b_request_in = 1'b1;
    wait_out(W_SEL, 1'b1, {tag, "_sel_up"});
    b_bus_in         = a;
    b_operational_in = 1'b1;
    b_address_in     = 1'b1;
    b_request_in     = 1'b0;
    wait_out(W_CMD, 1'b1, {tag, "_cmd_up"});
    b_address_in = 1'b0;
    wait_out(W_CMD, 1'b0, {tag, "_cmd_down"});
    b_bus_in    = s;
    b_status_in = 1'b1;
    wait_out(W_SVC, 1'b1, {tag, "_svc_up"});
    b_status_in = 1'b0;
    wait_out(W_SVC, 1'b0, {tag, "_svc_down"});
    check({tag, "_hold_sel_drop"}, 32'({b_hold_out, b_select_out}), 32'd0);
    b_operational_in = 1'b0;
    wait_out(W_BUSY, 1'b0, {tag, "_idle"});
    check({tag, "_tags_after"}, tags_out(), 32'd0);
  endtask

  // Scoreboard monitor: every poll_done must match the oldest expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge aclk);
      if (poll_done === 1'b1) begin
        if (sb.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL done_unexpected: poll_done with result %0d, expected no poll_done", poll_result);
        end else begin
          e = sb.pop_front();
          check("sb_result", 32'(poll_result), 32'(e.result));
          if (e.result == RESULT_OK) begin
            check("sb_address", 32'(poll_address), 32'(e.addr));
            check("sb_status", 32'(poll_status), 32'(e.status));
          end
        end
      end
    end
  end

  initial begin
    logic seen;
    int   n;

    aresetn          = 1'b1;
    poll_enable      = 1'b0;
    b_bus_in         = '0;
    b_request_in     = 1'b0;
    b_operational_in = 1'b0;
    b_address_in     = 1'b0;
    b_status_in      = 1'b0;
    b_select_in      = 1'b0;
    #2 aresetn = 1'b0;
    #1 check("reset_outputs", all_outs(), 32'd0);
    repeat (3) @(negedge aclk);
    aresetn = 1'b1;
    @(negedge aclk);
    check("reset_idle_busy", 32'(poll_busy), 32'd0);

    // Normal poll.
    ok_poll(8'h42, 8'h0C, "ok1");
    repeat (3) @(negedge aclk);

    // No response: select_in returns 3 cycles after select_out.
    push_exp(RESULT_NO_RESPONSE, 8'h00, 8'h00);
    poll_enable  = 1'b1;
    b_request_in = 1'b1;
    wait_out(W_SEL, 1'b1, "nr_sel_up");
    repeat (3) @(negedge aclk);
    b_select_in  = 1'b1;
    b_request_in = 1'b0;
    seen = 1'b0;
    n    = 0;
    while (poll_done !== 1'b1 && n < BUDGET) begin
      @(negedge aclk);
      seen = seen | b_command_out;
      n++;
    end
    check("nr_done_seen", 32'(poll_done), 32'd1);
    check("nr_cmd_never", 32'(seen), 32'd0);
    check("nr_hold_sel_drop", 32'({b_hold_out, b_select_out}), 32'd0);
    b_select_in = 1'b0;
    repeat (4) @(negedge aclk);

    // address_in and select_in arrive together: address branch wins.
    push_exp(RESULT_OK, 8'h5A, 8'h33);
    b_request_in = 1'b1;
    wait_out(W_SEL, 1'b1, "sim_sel_up");
    b_bus_in         = 8'h5A;
    b_operational_in = 1'b1;
    b_address_in     = 1'b1;
    b_select_in      = 1'b1;
    b_request_in     = 1'b0;
    wait_out(W_CMD, 1'b1, "sim_cmd_up");
    check("sim_busy", 32'(poll_busy), 32'd1);
    b_select_in  = 1'b0;
    b_address_in = 1'b0;
    wait_out(W_CMD, 1'b0, "sim_cmd_down");
    b_bus_in    = 8'h33;
    b_status_in = 1'b1;
    wait_out(W_SVC, 1'b1, "sim_svc_up");
    b_status_in = 1'b0;
    wait_out(W_SVC, 1'b0, "sim_svc_down");
    b_operational_in = 1'b0;
    wait_out(W_BUSY, 1'b0, "sim_idle");
    repeat (3) @(negedge aclk);

    // Timeout: address_in never drops; abort 16 cycles after entering ADDR_ACK.
    push_exp(RESULT_TIMEOUT, 8'h00, 8'h00);
    b_request_in = 1'b1;
    wait_out(W_SEL, 1'b1, "tmo_sel_up");
    b_bus_in         = 8'h77;
    b_operational_in = 1'b1;
    b_address_in     = 1'b1;
    b_request_in     = 1'b0;
    wait_out(W_CMD, 1'b1, "tmo_cmd_up");
    repeat (15) @(negedge aclk);
    check("tmo_cmd_still_up", 32'(b_command_out), 32'd1);
    @(negedge aclk);
    check("tmo_tags_drop", tags_out(), 32'd0);
    check("tmo_done", 32'(poll_done), 32'd1);
    b_address_in     = 1'b0;
    b_operational_in = 1'b0;
    repeat (4) @(negedge aclk);

    // Gating: request without poll_enable is ignored.
    poll_enable  = 1'b0;
    b_request_in = 1'b1;
    seen = 1'b0;
    repeat (100) begin
      @(negedge aclk);
      seen = seen | b_hold_out | b_select_out | b_command_out | b_service_out | poll_busy;
    end
    check("gate_quiet", 32'(seen), 32'd0);
    push_exp(RESULT_NO_RESPONSE, 8'h00, 8'h00);
    poll_enable = 1'b1;
    @(negedge aclk);
    check("gate_start", 32'({b_hold_out, b_select_out}), 32'd3);
    b_select_in  = 1'b1;
    b_request_in = 1'b0;
    wait_out(W_BUSY, 1'b0, "gate_idle");
    b_select_in = 1'b0;
    repeat (4) @(negedge aclk);

    // Reset asserted while waiting for status_in.
    b_request_in = 1'b1;
    wait_out(W_SEL, 1'b1, "rst_sel_up");
    b_bus_in         = 8'h99;
    b_operational_in = 1'b1;
    b_address_in     = 1'b1;
    b_request_in     = 1'b0;
    wait_out(W_CMD, 1'b1, "rst_cmd_up");
    b_address_in = 1'b0;
    wait_out(W_CMD, 1'b0, "rst_cmd_down");
    check("rst_busy_before", 32'(poll_busy), 32'd1);
    #2 aresetn = 1'b0;
    #1 check("rst_async_outputs", all_outs(), 32'd0);
    b_operational_in = 1'b0;
    repeat (2) @(negedge aclk);
    aresetn = 1'b1;
    repeat (2) @(negedge aclk);
    check("rst_idle_after", 32'(poll_busy), 32'd0);
    ok_poll(8'hA5, 8'h3C, "ok2");

    repeat (5) @(negedge aclk);
    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Hard time limit so the run always ends.
  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete, expected completion before limit");
    $fatal(1, "time limit reached");
  end

endmodule
